alu_cmd_driver: RTL and testbench
=================================

// Module: alu_cmd_driver
// PURPOSE
//  Initiator side of the 2-bit-select ALU interface: accepts operation commands over a valid/ready
//  port, drives S/A/B into an external combinational ALU, waits a settle window, samples the
//  result and returns it over a valid/ready response port. Sits between a test/control sequencer
//  and the ALU datapath; one command in flight at a time.
// PARAMETERS
//  W       3   operand width (cmd_a, cmd_b, alu_a, alu_b)
//  SETTLE  1   cycles between driving the ALU and sampling alu_ans; legal range 1..15
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  cmd_valid  in   1     command present
//  cmd_ready  out  1     driver can accept a command
//  cmd_op     in   2     0 ADD, 1 SUB, 2 AND, 3 OR
//  cmd_a      in   W     operand A
//  cmd_b      in   W     operand B
//  alu_s      out  2     registered select to ALU
//  alu_a      out  W     registered operand A to ALU
//  alu_b      out  W     registered operand B to ALU
//  alu_ans    in   W+2   ALU result (combinational from alu_s/a/b)
//  rsp_valid  out  1     response present
//  rsp_ready  in   1     consumer takes response
//  rsp_op     out  2     op of the returned response
//  rsp_ans    out  W+2   sampled alu_ans
//  rsp_err    out  1     golden-model mismatch (ALU_DRV_CHECK_EN only; else 0)
//  err_cnt    out  8     saturating mismatch count (ALU_DRV_CHECK_EN only; else 0)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; cmd_ready=0 during reset, 1 first cycle after;
//   alu_s/a/b, rsp_*, err_cnt = 0; settle counter = 0.
//  FSM IDLE -> DRIVE -> RESP -> IDLE.
//   IDLE: cmd_ready=1. Edge e0 with cmd_valid&cmd_ready: latch op/a/b into alu_s/a/b and rsp_op,
//    load counter = SETTLE-1, go DRIVE.
//   DRIVE: cmd_ready=0. Counter decrements each edge; at the edge where counter==0, capture
//    alu_ans into rsp_ans, set rsp_valid, go RESP. rsp_valid first high after edge e0+SETTLE.
//   RESP: rsp_valid, rsp_op, rsp_ans, rsp_err held stable until edge with rsp_ready=1; then
//    rsp_valid=0, go IDLE. cmd_ready returns high the cycle after the response handshake.
//  Max throughput: one command per SETTLE+2 cycles with rsp_ready tied high.
//  alu_s/a/b hold last issued values in IDLE/RESP (not cleared); change only at acceptance.
//  cmd_* ignored when cmd_ready=0; rsp_ready ignored when rsp_valid=0.
//  Arithmetic contract (expected ALU behaviour, used by checker): operands zero-extended to W+2;
//   ADD = a+b; SUB = (a-b) mod 2^(W+2) (2-5 -> 29 for W=3); AND/OR bitwise, upper 2 bits 0.
//  Reset mid-operation: in-flight command dropped, no response issued, err_cnt cleared.
// CONFIGURATION
//  ALU_DRV_CHECK_EN defined: alu_golden computes expected result from alu_s/a/b; at capture edge
//   rsp_err = (alu_ans != expected); err_cnt increments on each mismatch, saturates at 255.
//  Undefined: no golden model instantiated; rsp_err and err_cnt tied to 0; ports retained.
// STRUCTURE
//  Package alu_pkg: opcode localparams OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3; FSM state
//   encodings ST_IDLE/ST_DRIVE/ST_RESP; result-width constant RW = W+2.
//  Sub-module alu_golden (combinational, params W): expected-result model; instantiated only
//   under ALU_DRV_CHECK_EN.
// TESTING
//  1. ADD a=3,b=4, SETTLE=1, rsp_ready=1 -> rsp_valid at e0+1, rsp_ans=7, rsp_op=0, rsp_err=0.
//  2. SUB a=2,b=5 -> rsp_ans=29 (5'b11101); SUB a=7,b=0 -> 7.
//  3. AND 6,3 -> 2; OR 5,2 -> 7; SETTLE=4 -> rsp_valid exactly 4 cycles after acceptance.
//  4. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_ans stable, cmd_ready=0, new cmd_valid
//     ignored; release -> cmd_ready high next cycle.
//  5. Assert rst_n=0 in DRIVE -> all outputs 0 immediately; after release no stale rsp_valid.
//  6. ALU_DRV_CHECK_EN with ALU stub forcing alu_ans=0 on ADD 1+1 -> rsp_err=1, err_cnt=1;
//     300 such commands -> err_cnt=255.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command driver: opcodes, FSM states, result width.
package alu_pkg;

   localparam int ALU_W = 3;
   localparam int RW    = ALU_W + 2;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_golden.sv
// Expected-result model of the external ALU. Operands are zero-extended to W+2,
// SUB wraps modulo 2^(W+2), logic ops leave the two upper bits clear.
module alu_golden
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic [1:0]   s_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W+1:0] exp_o
);

   // Pure combinational reference result for the current select/operands.
   always_comb begin
      exp_o = '0;
      case (s_i)
         OP_ADD:  exp_o = {2'b00, a_i} + {2'b00, b_i};
         OP_SUB:  exp_o = {2'b00, a_i} - {2'b00, b_i};
         OP_AND:  exp_o = {2'b00, a_i & b_i};
         OP_OR:   exp_o = {2'b00, a_i | b_i};
         default: exp_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for a 2-bit-select combinational ALU: accepts one command at a time,
// drives registered S/A/B, waits SETTLE cycles, samples the result and returns it.
// Optional golden-model checking is compiled in with ALU_DRV_CHECK_EN.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int W      = ALU_W,
   parameter int SETTLE = 1          // 1..15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic [1:0]   alu_s,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W+1:0] alu_ans,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [1:0]   rsp_op,
   output logic [W+1:0] rsp_ans,
   output logic         rsp_err,
   output logic [7:0]   err_cnt
);

   localparam int          LRW       = W + 2;
   localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic             ready_q;
   logic             rsp_valid_q;
   logic [1:0]       s_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [LRW-1:0]   ans_q;

   // Command/response FSM; ready comes up one edge after reset release so the
   // consumer never sees cmd_ready while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         s_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ans_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (cmd_valid && ready_q) begin
                  s_q     <= cmd_op;
                  a_q     <= cmd_a;
                  b_q     <= cmd_b;
                  cnt_q   <= SETTLE_M1;
                  ready_q <= 1'b0;
                  state_q <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == 4'd0) begin
                  ans_q       <= alu_ans;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = ready_q;
   assign alu_s     = s_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_valid = rsp_valid_q;
   // Select only changes at acceptance, so it doubles as the returned opcode.
   assign rsp_op    = s_q;
   assign rsp_ans   = ans_q;

`ifdef ALU_DRV_CHECK_EN
   logic [LRW-1:0] exp_ans;
   logic           capture;
   logic           mism;
   logic           err_q;
   logic [7:0]     err_cnt_q;
   logic [7:0]     err_cnt_d;

   alu_golden #(.W(W)) u_golden (
      .s_i   (s_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .exp_o (exp_ans)
   );

   assign capture   = (state_q == ST_DRIVE) && (cnt_q == 4'd0);
   assign mism      = (alu_ans != exp_ans);
   assign err_cnt_d = (mism && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

   // Mismatch flag is refreshed only at the sample edge so it stays aligned with rsp_ans.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else if (capture) begin
         err_q     <= mism;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign rsp_err = err_q;
   assign err_cnt = err_cnt_q;
`else
   assign rsp_err = 1'b0;
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: directed commands, expected responses queued into a
// scoreboard and checked by an independent monitor at each response handshake.
module tb_alu_cmd_driver;

`ifdef ALU_DRV_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic [1:0] op;
      logic [4:0] ans;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_op;
   logic [2:0] cmd_a, cmd_b;
   logic [1:0] alu_s;
   logic [2:0] alu_a, alu_b;
   logic [4:0] alu_ans;
   logic       rsp_valid, rsp_ready;
   logic [1:0] rsp_op;
   logic [4:0] rsp_ans;
   logic       rsp_err;
   logic [7:0] err_cnt;
   logic       stub_zero;

   // second instance, SETTLE=4
   logic       c4_valid, c4_ready;
   logic [1:0] c4_op;
   logic [2:0] c4_a, c4_b;
   logic [1:0] a4_s;
   logic [2:0] a4_a, a4_b;
   logic [4:0] a4_ans;
   logic       r4_valid;
   logic       r4_ready;
   logic [1:0] r4_op;
   logic [4:0] r4_ans;
   logic       r4_err;
   logic [7:0] e4_cnt;

   exp_t sb[$];
   int   ntests = 0;
   int   nfail  = 0;

   always #5 clk = ~clk;

   // external ALU stub; stub_zero forces a wrong (zero) result
   function automatic logic [4:0] alu_model(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
      case (s)
         2'd0:    return {2'b00, a} + {2'b00, b};
         2'd1:    return {2'b00, a} - {2'b00, b};
         2'd2:    return {2'b00, a & b};
         default: return {2'b00, a | b};
      endcase
   endfunction

   always_comb alu_ans = stub_zero ? 5'd0 : alu_model(alu_s, alu_a, alu_b);
   always_comb a4_ans  = alu_model(a4_s, a4_a, a4_b);

   alu_cmd_driver #(.W(3), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_ans(rsp_ans),
      .rsp_err(rsp_err), .err_cnt(err_cnt)
   );

   alu_cmd_driver #(.W(3), .SETTLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_op(c4_op), .cmd_a(c4_a), .cmd_b(c4_b),
      .alu_s(a4_s), .alu_a(a4_a), .alu_b(a4_b), .alu_ans(a4_ans),
      .rsp_valid(r4_valid), .rsp_ready(r4_ready), .rsp_op(r4_op), .rsp_ans(r4_ans),
      .rsp_err(r4_err), .err_cnt(e4_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // monitor: compare every response at the cycle its handshake completes
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_op",  32'(rsp_op),  32'(e.op));
            check("rsp_ans", 32'(rsp_ans), 32'(e.ans));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   end

   // caller is always at posedge+1
   task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [4:0] ans, input logic err);
      int t = 0;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
      sb.push_back('{op: op, ans: ans, err: err});
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!rsp_valid && lat < 50);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      rsp_ready = 1'b1; stub_zero = 1'b0;
      c4_valid = 1'b0; c4_op = '0; c4_a = '0; c4_b = '0; r4_ready = 1'b1;

      // reset state
      #12;
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_alu_a",     32'(alu_a), 0);
      check("rst_err_cnt",   32'(err_cnt), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rel_cmd_ready_before_edge", 32'(cmd_ready), 0);
      @(posedge clk); #1;
      check("rel_cmd_ready", 32'(cmd_ready), 1);

      // ADD with latency check
      send(2'd0, 3'd3, 3'd4, 5'd7, 1'b0);
      wait_rsp(lat);
      check("lat_settle1", 32'(lat), 1);
      check("alu_s_add", 32'(alu_s), 0);

      send(2'd1, 3'd2, 3'd5, 5'd29, 1'b0);
      send(2'd1, 3'd7, 3'd0, 5'd7,  1'b0);
      send(2'd2, 3'd6, 3'd3, 5'd2,  1'b0);
      send(2'd3, 3'd5, 3'd2, 5'd7,  1'b0);
      send(2'd0, 3'd7, 3'd7, 5'd14, 1'b0);
      send(2'd1, 3'd0, 3'd7, 5'd25, 1'b0);

      // back-pressure: response held, new command ignored
      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1'b0;
      send(2'd0, 3'd1, 3'd2, 5'd3, 1'b0);
      wait_rsp(lat);
      check("lat_stall", 32'(lat), 1);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_a = 3'd7; cmd_b = 3'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_rsp_valid", 32'(rsp_valid), 1);
         check("stall_rsp_ans",   32'(rsp_ans), 3);
         check("stall_cmd_ready", 32'(cmd_ready), 0);
         check("stall_alu_a",     32'(alu_a), 1);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("post_hs_cmd_ready", 32'(cmd_ready), 1);
      check("post_hs_rsp_valid", 32'(rsp_valid), 0);

      // reset while in DRIVE: command dropped
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 3'd2; cmd_b = 3'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("drive_alu_a", 32'(alu_a), 2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_alu_a",     32'(alu_a), 0);
      check("mid_rst_rsp_ans",   32'(rsp_ans), 0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("no_stale_rsp", 32'(rsp_valid), 0);
      end
      check("rst_cmd_ready_back", 32'(cmd_ready), 1);

      // SETTLE=4 instance
      for (int i = 0; i < 50 && !c4_ready; i++) begin
         @(posedge clk); #1;
      end
      c4_valid = 1'b1; c4_op = 2'd3; c4_a = 3'd5; c4_b = 3'd2;
      @(posedge clk); #1;
      c4_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!r4_valid && lat < 50);
      check("lat_settle4", 32'(lat), 4);
      check("s4_rsp_ans",  32'(r4_ans), 7);
      check("s4_rsp_op",   32'(r4_op), 3);

      // faulty ALU: mismatch flagged only when checking is built in
      stub_zero = 1'b1;
      send(2'd0, 3'd1, 3'd1, 5'd0, CHK);
      wait_rsp(lat);
      check("err_cnt_one", 32'(err_cnt), CHK ? 1 : 0);
      if (CHK) begin
         for (int i = 0; i < 299; i++) send(2'd0, 3'd1, 3'd1, 5'd0, 1'b1);
         wait_rsp(lat);
         check("err_cnt_sat", 32'(err_cnt), 255);
      end
      stub_zero = 1'b0;

      for (int i = 0; i < 50 && sb.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("sb_drained", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
